// File: rtl/fog_sq_demod_if.sv
// Sample/strobe bus between the modulation chain and the square-wave demodulator.
// The master side drives phase, step trigger and ADC sample; the slave returns the error.
interface fog_sq_demod_if #(
  parameter int ADC_BIT = 14,
  parameter int ACC_BIT = 32
);
  logic                      i_status;
  logic                      i_step_trig;
  logic signed [ADC_BIT-1:0] i_adc;
  logic signed [ACC_BIT-1:0] o_err;
  logic                      o_err_vld;

  modport master (
    output i_status, i_step_trig, i_adc,
    input  o_err, o_err_vld
  );

  modport slave (
    input  i_status, i_step_trig, i_adc,
    output o_err, o_err_vld
  );
endinterface

// File: rtl/fog_sq_demod.sv
// Square-wave synchronous demodulator: settles after each phase step, integrates HIGH and
// LOW halves separately over 2^avg_sel periods and emits the saturated difference.
module fog_sq_demod #(
  parameter int ADC_BIT = 14,
  parameter int ACC_BIT = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  fog_sq_demod_if.slave        bus,
  input  logic [15:0]          i_wait_cnt,
  input  logic [2:0]           i_avg_sel,
  input  logic                 i_polarity,
  output logic [1:0]           o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACC  = 2'd2
  } state_t;

  state_t                    state;
  logic                      phase;
  logic [15:0]               wait_ctr;
  logic [7:0]                period_cnt;
  logic [2:0]                avg_sel_r;
  logic                      pol_r;
  logic signed [ACC_BIT-1:0] sum_h;
  logic signed [ACC_BIT-1:0] sum_l;
  logic signed [ACC_BIT-1:0] err_p1;
  logic                      vld_p1;
  logic signed [ACC_BIT-1:0] adc_ext;
  logic                      last_period;

  // Difference is formed one bit wider so neither the subtraction nor the negation can wrap.
  function automatic logic signed [ACC_BIT-1:0] sat_err(
    input logic signed [ACC_BIT-1:0] h,
    input logic signed [ACC_BIT-1:0] l,
    input logic                      neg
  );
    logic signed [ACC_BIT:0] d;
    d = {h[ACC_BIT-1], h} - {l[ACC_BIT-1], l};
    if (neg) d = -d;
    if (d[ACC_BIT] != d[ACC_BIT-1])
      return d[ACC_BIT] ? {1'b1, {(ACC_BIT-1){1'b0}}} : {1'b0, {(ACC_BIT-1){1'b1}}};
    return d[ACC_BIT-1:0];
  endfunction

  assign adc_ext     = {{(ACC_BIT-ADC_BIT){bus.i_adc[ADC_BIT-1]}}, bus.i_adc};
  assign last_period = (period_cnt == ((8'd1 << avg_sel_r) - 8'd1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      phase      <= 1'b0;
      wait_ctr   <= '0;
      period_cnt <= '0;
      avg_sel_r  <= '0;
      pol_r      <= 1'b0;
      sum_h      <= '0;
      sum_l      <= '0;
      err_p1     <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (bus.i_step_trig) begin
        if (state == IDLE) begin
          if (!bus.i_status) begin
            sum_h      <= '0;
            sum_l      <= '0;
            period_cnt <= '0;
            phase      <= 1'b0;
            wait_ctr   <= i_wait_cnt;
            avg_sel_r  <= i_avg_sel;
            pol_r      <= i_polarity;
            state      <= WAIT;
          end
        end else if (bus.i_status == phase) begin
          // A step without a phase change means we lost lock to the generator.
          sum_h      <= '0;
          sum_l      <= '0;
          period_cnt <= '0;
          state      <= IDLE;
        end else begin
          phase    <= bus.i_status;
          wait_ctr <= i_wait_cnt;
          state    <= WAIT;
          if (phase && !bus.i_status) begin
            if (last_period) begin
              err_p1     <= sat_err(sum_h, sum_l, pol_r);
              vld_p1     <= 1'b1;
              sum_h      <= '0;
              sum_l      <= '0;
              period_cnt <= '0;
              avg_sel_r  <= i_avg_sel;
              pol_r      <= i_polarity;
            end else begin
              period_cnt <= period_cnt + 8'd1;
            end
          end
        end
      end else begin
        case (state)
          WAIT: begin
            if (wait_ctr != 16'd0) begin
              wait_ctr <= wait_ctr - 16'd1;
            end else begin
              state <= ACC;
              if (phase) sum_h <= sum_h + adc_ext;
              else       sum_l <= sum_l + adc_ext;
            end
          end
          ACC: begin
            if (phase) sum_h <= sum_h + adc_ext;
            else       sum_l <= sum_l + adc_ext;
          end
          default: ;
        endcase
      end
    end
  end

  // Output stage p1
  assign bus.o_err     = err_p1;
  assign bus.o_err_vld = vld_p1;
  assign o_state       = state;

endmodule

// File: tb/tb_fog_sq_demod.sv
// Bench for fog_sq_demod: directed scenarios plus randomized halves, checked against a
// half-period level reference model; a 16-bit instance covers output saturation.
module tb_fog_sq_demod;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fog_sq_demod_if #(.ADC_BIT(14), .ACC_BIT(32)) m_if ();
  fog_sq_demod_if #(.ADC_BIT(14), .ACC_BIT(16)) s_if ();

  logic [15:0] wait_cnt = 16'd2;
  logic [2:0]  avg_sel  = 3'd0;
  logic        polarity = 1'b0;
  logic [1:0]  state_m;
  logic [15:0] s_wait   = 16'd0;
  logic [2:0]  s_avg    = 3'd0;
  logic        s_pol    = 1'b0;
  logic [1:0]  state_s;

  assign s_if.i_status    = m_if.i_status;
  assign s_if.i_step_trig = m_if.i_step_trig;
  assign s_if.i_adc       = m_if.i_adc;

  fog_sq_demod #(.ADC_BIT(14), .ACC_BIT(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(m_if),
    .i_wait_cnt(wait_cnt), .i_avg_sel(avg_sel), .i_polarity(polarity), .o_state(state_m)
  );

  fog_sq_demod #(.ADC_BIT(14), .ACC_BIT(16)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .bus(s_if),
    .i_wait_cnt(s_wait), .i_avg_sel(s_avg), .i_polarity(s_pol), .o_state(state_s)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model, tracked per half-period from the samples seen since the last step
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;
  bit     m_act;
  bit     m_ph;
  int     m_w;
  int     m_pc;
  int     m_avg;
  bit     m_pol;
  longint m_sh;
  longint m_sl;
  longint q[$];
  logic                exp_vld = 1'b0;
  logic signed [31:0]  exp_err = '0;
  int                  const_q[$];
  bit                  no_acc = 1'b0;
  bit                  sat_chk = 1'b0;
  logic signed [15:0]  sat_exp = 16'sd32767;

  function automatic longint wrap32(input longint v);
    return longint'(int'(v));
  endfunction

  function automatic longint sat_model(input longint h, input longint l, input bit neg);
    longint d;
    d = h - l;
    if (neg) d = -d;
    if (d > MAXV) return MAXV;
    if (d < MINV) return MINV;
    return d;
  endfunction

  task automatic model_step(input bit step, input bit st, input logic signed [13:0] adc);
    longint c;
    exp_vld = 1'b0;
    if (!step) begin
      if (m_act) q.push_back(longint'(adc));
      return;
    end
    if (m_act) begin
      c = 0;
      for (int i = m_w; i < q.size(); i++) c += q[i];
      if (m_ph) m_sh = wrap32(m_sh + c);
      else      m_sl = wrap32(m_sl + c);
      q.delete();
      if (st == m_ph) begin
        m_act = 0;
      end else begin
        if (m_ph && !st) begin
          if (m_pc == (1 << m_avg) - 1) begin
            exp_vld = 1'b1;
            exp_err = 32'(sat_model(m_sh, m_sl, m_pol));
            m_sh = 0; m_sl = 0; m_pc = 0;
            m_avg = int'(avg_sel); m_pol = polarity;
          end else begin
            m_pc++;
          end
        end
        m_ph = st;
        m_w  = int'(wait_cnt);
      end
    end else if (!st) begin
      m_act = 1; m_ph = 0; m_sh = 0; m_sl = 0; m_pc = 0;
      m_avg = int'(avg_sel); m_pol = polarity; m_w = int'(wait_cnt);
      q.delete();
    end
  endtask

  task automatic tick(input bit step, input bit st, input logic signed [13:0] adc);
    int c;
    m_if.i_step_trig = step;
    m_if.i_status    = st;
    m_if.i_adc       = adc;
    model_step(step, st, adc);
    @(posedge clk);
    #1;
    n_chk++;
    assert (m_if.o_err_vld === exp_vld) else begin
      n_fail++; $error("FAIL err_vld observed=%0b expected=%0b t=%0t", m_if.o_err_vld, exp_vld, $time);
    end
    n_chk++;
    assert (m_if.o_err === exp_err) else begin
      n_fail++; $error("FAIL err observed=%0d expected=%0d t=%0t", m_if.o_err, exp_err, $time);
    end
    if (exp_vld && const_q.size() > 0) begin
      c = const_q.pop_front();
      n_chk++;
      assert (m_if.o_err === 32'(c)) else begin
        n_fail++; $error("FAIL err_const observed=%0d expected=%0d", m_if.o_err, c);
      end
    end
    if (no_acc) begin
      n_chk++;
      assert (state_m !== 2'd2) else begin
        n_fail++; $error("FAIL no_acc observed=%0d expected=not 2", state_m);
      end
    end
    if (sat_chk && step && !st) begin
      n_chk++;
      assert (s_if.o_err_vld === 1'b1 && s_if.o_err === sat_exp) else begin
        n_fail++; $error("FAIL sat observed=%0d/%0b expected=%0d/1", s_if.o_err, s_if.o_err_vld, sat_exp);
      end
    end
  endtask

  function automatic logic signed [13:0] adc_v(input bit st, input int amp, input bit rnd);
    if (rnd) return 14'($urandom_range(0, 16383));
    return st ? 14'(amp) : 14'(-amp);
  endfunction

  task automatic half(input bit st, input int d, input int amp, input bit rnd);
    tick(1'b1, st, adc_v(st, amp, rnd));
    for (int i = 1; i < d; i++) tick(1'b0, st, adc_v(st, amp, rnd));
  endtask

  task automatic period(input int amp);
    half(1'b0, 10, amp, 1'b0);
    half(1'b1, 10, amp, 1'b0);
  endtask

  task automatic do_reset(input int n);
    m_if.i_step_trig = 1'b0;
    rst_n = 1'b0;
    m_act = 0; q.delete(); exp_vld = 1'b0; exp_err = '0;
    #1;
    n_chk++;
    assert (m_if.o_err === 32'sd0 && m_if.o_err_vld === 1'b0 && state_m === 2'd0) else begin
      n_fail++; $error("FAIL reset observed=%0d/%0b/%0d expected=0/0/0", m_if.o_err, m_if.o_err_vld, state_m);
    end
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit cur;
    bit st;
    m_if.i_status = 1'b0;
    m_if.i_step_trig = 1'b0;
    m_if.i_adc = '0;

    // Basic demodulation, then averaging and a mid-block polarity change
    do_reset(3);
    wait_cnt = 16'd2; avg_sel = 3'd0; polarity = 1'b0;
    repeat (5) const_q.push_back(1400);
    repeat (6) period(100);
    avg_sel = 3'd2;
    const_q.push_back(1400); const_q.push_back(5600);
    const_q.push_back(5600); const_q.push_back(-5600);
    repeat (5) period(100);
    half(1'b0, 10, 100, 1'b0);
    polarity = 1'b1;
    half(1'b1, 10, 100, 1'b0);
    repeat (7) period(100);
    const_q.delete();

    // Settling window longer than the half-period
    do_reset(2);
    wait_cnt = 16'd12; avg_sel = 3'd0; polarity = 1'b0;
    no_acc = 1'b1;
    repeat (3) const_q.push_back(0);
    repeat (4) period(100);
    no_acc = 1'b0;
    const_q.delete();

    // Resync on a step without phase change
    do_reset(2);
    wait_cnt = 16'd2;
    repeat (3) const_q.push_back(1400);
    repeat (2) period(100);
    half(1'b0, 5, 100, 1'b0);
    tick(1'b1, 1'b0, -14'sd100);
    n_chk++;
    assert (state_m === 2'd0) else begin
      n_fail++; $error("FAIL resync_state observed=%0d expected=0", state_m);
    end
    repeat (4) tick(1'b0, 1'b0, -14'sd100);
    half(1'b1, 10, 100, 1'b0);
    repeat (2) period(100);
    const_q.delete();

    // Reset in the middle of an averaging block
    do_reset(2);
    avg_sel = 3'd2; wait_cnt = 16'd2;
    const_q.push_back(5600);
    repeat (2) period(100);
    tick(1'b1, 1'b0, -14'sd100);
    repeat (3) tick(1'b0, 1'b0, -14'sd100);
    do_reset(3);
    repeat (5) period(100);
    const_q.delete();

    // Saturation on the 16-bit instance
    do_reset(2);
    avg_sel = 3'd0; wait_cnt = 16'd2; s_pol = 1'b0;
    period(3000);
    sat_exp = 16'sd32767; sat_chk = 1'b1;
    repeat (3) period(3000);
    s_pol = 1'b1;
    half(1'b0, 10, 3000, 1'b0);
    half(1'b1, 10, 3000, 1'b0);
    sat_exp = -16'sd32768;
    period(3000);
    half(1'b0, 10, 3000, 1'b0);
    sat_chk = 1'b0;
    half(1'b1, 10, 3000, 1'b0);
    s_pol = 1'b0;

    // Randomized halves, configuration changes and occasional resyncs
    do_reset(2);
    cur = 1'b1;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        wait_cnt = 16'($urandom_range(0, 12));
        avg_sel  = 3'($urandom_range(0, 2));
        polarity = 1'($urandom_range(0, 1));
      end
      st = ($urandom_range(0, 9) == 0) ? cur : !cur;
      cur = st;
      half(st, int'($urandom_range(1, 14)), 0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fog_sq_demod.md
# fog_sq_demod

Square-wave synchronous demodulator for the PIG/FOG closed-loop chain. It sits directly downstream of the square-wave modulation generator and consumes its phase flag and step-trigger pulse, together with the photodetector ADC sample stream. After each phase step it discards a programmable settling window, then accumulates samples separately for the HIGH and LOW half-periods. Over 2^N full modulation periods it emits a saturated signed error `sum_H - sum_L` for the loop filter.

## Interface
- `ADC_BIT`, 14: width of signed ADC sample.
- `ACC_BIT`, 32: width of half-period accumulators and error output, signed.

- `i_clk`  in  1  system clock, the same domain as the modulation generator.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_status`  in  1  modulation phase from the generator (1 = HIGH half, 0 = LOW half).
- `i_step_trig`  in  1  one-cycle pulse at each half-period boundary. `i_status` already holds the new phase in that cycle.
- `i_adc`  in  ADC_BIT  signed ADC sample, valid every clock.
- `i_wait_cnt`  in  16  number of samples discarded after the step cycle.
- `i_avg_sel`  in  3  accumulate 2^i_avg_sel full periods per output (1..128).
- `i_polarity`  in  1  1 = negate error output.
- `o_err`  out  ACC_BIT  signed demodulated error, registered.
- `o_err_vld`  out  1  one-cycle strobe when `o_err` updates.
- `o_state`  out  2  FSM state, for simulation and debug (0 IDLE, 1 WAIT, 2 ACC).

## Operation
- **FSM states:** IDLE, WAIT, ACC.
- **IDLE:**
  - Ignores samples.
  - On `i_step_trig && !i_status` (start of a LOW half):
    - clear `sum_H`, `sum_L` and `period_cnt`;
    - latch `phase <= 0`;
    - load `wait_ctr <= i_wait_cnt`;
    - latch `i_avg_sel` and `i_polarity` into working registers;
    - go to WAIT.
- **Step handling in WAIT or ACC:**
  - The sample in the step cycle is always discarded.
  - If `i_status == phase` (no actual phase change): resync. Clear sums and `period_cnt`, no output, go to IDLE.
  - Otherwise latch `phase <= i_status`, load `wait_ctr <= i_wait_cnt`, go to WAIT.
  - If the old phase was HIGH and the new phase is LOW, one full period has completed. Then:
    - if `period_cnt == 2^avg_sel - 1`, output `sum_H - sum_L`, clear sums and `period_cnt`, and re-latch `i_avg_sel` and `i_polarity`;
    - otherwise `period_cnt++`.
- **WAIT (no step in this cycle):**
  - If `wait_ctr != 0`: discard the sample, `wait_ctr--`.
  - If `wait_ctr == 0`: go to ACC and accumulate this sample.
  - With `i_wait_cnt = 0`, accumulation therefore starts the cycle after the step.
- **ACC (no step in this cycle):** add sign-extended `i_adc` to `sum_H` if `phase == 1`, else to `sum_L`.
- **Window longer than the half-period:** if `i_wait_cnt` meets or exceeds the half-period, nothing is accumulated for that half. This is legal; its contribution is 0.
- **Arithmetic:**
  - `i_adc` is sign-extended to ACC_BIT.
  - Sums wrap modulo 2^ACC_BIT; sizing ACC_BIT to avoid sum wrap is the integrator's responsibility.
  - The difference is computed in ACC_BIT+1 bits, optionally negated (`i_polarity`), then saturated to the ACC_BIT signed range [-2^(ACC_BIT-1), 2^(ACC_BIT-1)-1].
- **Configuration changes:** `i_wait_cnt` takes effect at the next step. `i_avg_sel` and `i_polarity` take effect only at IDLE exit or an output boundary.

## Timing
- **Reset values:** `o_err = 0`, `o_err_vld = 0`, `o_state = 0` (IDLE), all internal counters and sums 0.
- **Output latency:** `o_err` and `o_err_vld` are registered. `o_err_vld` is high for exactly one cycle, the cycle after the completing `i_step_trig`. `o_err` holds its value until the next strobe.
- **Samples per half:** with D clocks between consecutive steps, each half accumulates max(0, D-1-i_wait_cnt) samples.
- **Async reset mid-operation:** aborts immediately. No `o_err_vld` is issued for the partial block. After release, the block waits in IDLE for the next LOW-start step.
- **Steps on consecutive cycles:** legal. Each is processed as above, with 0 samples accumulated between them.
- **Throughput:** no back-pressure; one sample is consumed per clock.

## Test plan
- **Basic demodulation:**
  - Stimulus: 10 clocks between steps, `i_adc` = +100 in HIGH and -100 in LOW, `i_wait_cnt` = 2, `i_avg_sel` = 0.
  - Response: 7 samples per half; `o_err` = 1400, with `o_err_vld` once per 20-clock period, one cycle after each HIGH→LOW step.
- **Averaging and polarity:**
  - Stimulus: as the basic scenario, with `i_avg_sel` = 2.
  - Response: `o_err` = 5600, strobe every 80 clocks.
  - Then set `i_polarity` = 1 mid-block. The current block still outputs 5600; the following block outputs -5600.
- **Long settling window:**
  - Stimulus: `i_wait_cnt` = 12 with 10-clock halves.
  - Response: `o_err` = 0 every period; the FSM never reaches ACC.
- **Saturation:**
  - Stimulus: ACC_BIT = 16, `i_adc` = +3000 (HIGH) and -3000 (LOW), `i_wait_cnt` = 0, 10-clock halves. This gives 9 samples per half and a raw difference of 54000.
  - Response: `o_err` = 32767. With `i_polarity` = 1: `o_err` = -32768.
- **Resync:**
  - Stimulus: inject an `i_step_trig` with `i_status` unchanged mid-period.
  - Response: `o_state` returns to 0 and there is no strobe for that period. The next valid `o_err` (1400 under the basic settings) follows the first complete period after the next LOW-start step.
- **Reset mid-block:**
  - Stimulus: assert `i_rst_n` low for 3 clocks in the middle of an `i_avg_sel` = 2 block.
  - Response: `o_err` = 0 and `o_err_vld` = 0 immediately; the first strobe after release reports the full 5600.
